// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared defaults and helpers for the multi-channel debouncer.
//   DEF_CHANNELS      default number of channels
//   DEF_TICK_DIV      default clk cycles per sample tick
//   DEF_STABLE_TICKS  default number of mismatching ticks before q changes
//   DEF_INIT_LEVEL    default reset level of q and the synchronisers
//   clog2_min1()      ceil(log2(value)), never less than 1 bit
// Optional feature macro used by the design: MULTI_DEBOUNCER_EDGE_EN
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int   DEF_CHANNELS     = 4;
   localparam int   DEF_TICK_DIV     = 10000;
   localparam int   DEF_STABLE_TICKS = 8;
   localparam logic DEF_INIT_LEVEL   = 1'b0;

   // Register width for a counter that must hold value-1; a zero-width
   // result (value of 1) is widened to a single bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: 2-flop synchroniser, stability counter, debounced
// level and optional edge pulses.
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   i_tick   shared sample tick from the prescaler (one cycle wide)
//   i_in     raw asynchronous input
//   o_q      debounced level (registered)
//   o_rise   one-cycle pulse in the first cycle o_q shows 1 after a 0
//   o_fall   one-cycle pulse in the first cycle o_q shows 0 after a 1
// Macro MULTI_DEBOUNCER_EDGE_EN: when undefined o_rise/o_fall are tied to 0
// and no edge registers exist.
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic INIT_LEVEL   = DEF_INIT_LEVEL
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_tick,
   input  logic i_in,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   localparam int             CW      = clog2_min1(STABLE_TICKS + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_TICKS - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_q;
   logic [CW-1:0] r_cnt;
   logic          w_mismatch;
   logic          w_load;

   assign w_mismatch = (r_sync2 != r_q);
   // Final qualifying tick: q takes the synchronised level on this edge.
   assign w_load     = w_mismatch & i_tick & (r_cnt == CNT_MAX);
   assign o_q        = r_q;

   // Synchroniser, stability counter and debounced level.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1 <= INIT_LEVEL;
         r_sync2 <= INIT_LEVEL;
         r_q     <= INIT_LEVEL;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_in;
         r_sync2 <= r_sync1;
         // Any cycle where the input agrees with q restarts qualification,
         // whether or not a tick is present.
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_load) begin
            r_q   <= r_sync2;
            r_cnt <= '0;
         end else if (i_tick) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

`ifdef MULTI_DEBOUNCER_EDGE_EN
   logic r_rise;
   logic r_fall;

   // Edge pulses are registered on the same edge that updates q.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_load &  r_sync2;
         r_fall <= w_load & ~r_sync2;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
// CHANNELS independent debouncers sharing one sample-tick prescaler.
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   in     raw asynchronous inputs, CHANNELS bits
//   q      debounced levels, registered
//   rise   one-cycle pulse per channel when q[i] goes 0->1
//   fall   one-cycle pulse per channel when q[i] goes 1->0
// Macro MULTI_DEBOUNCER_EDGE_EN: when undefined rise/fall are tied to 0.
// -----------------------------------------------------------------------------
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int   CHANNELS     = DEF_CHANNELS,
   parameter int   TICK_DIV     = DEF_TICK_DIV,
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic INIT_LEVEL   = DEF_INIT_LEVEL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   localparam int            PW        = clog2_min1(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic          w_tick;

   // With TICK_DIV of 1 the prescaler sits at 0 and ticks every cycle.
   assign w_tick = (r_presc == PRESC_MAX);

   // Shared prescaler counting 0..TICK_DIV-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .INIT_LEVEL   (INIT_LEVEL)
      ) u_channel (
         .i_clk   (clk),
         .i_reset (reset),
         .i_tick  (w_tick),
         .i_in    (in[g]),
         .o_q     (q[g]),
         .o_rise  (rise[g]),
         .o_fall  (fall[g])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
// Two instances share clk/reset: dut_a (TICK_DIV=4) and dut_b (TICK_DIV=1),
// both with CHANNELS=4, STABLE_TICKS=3, INIT_LEVEL=0.
// The reference model counts ticks arithmetically between the last edge at
// which the synchronised input agreed with q and the current edge.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

   localparam int STK  = 3;
   localparam int HMAX = 1024;
`ifdef MULTI_DEBOUNCER_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_a  = 4'b0000;
   logic [3:0] in_b  = 4'b0000;
   logic [3:0] q_a, rise_a, fall_a;
   logic [3:0] q_b, rise_b, fall_b;

   int n_vec = 0;
   int n_err = 0;

   // model state, index 0 = dut_a, 1 = dut_b
   int         edge_idx;
   logic [3:0] in_hist [2][HMAX];
   logic [3:0] mq [2];
   logic [3:0] er [2];
   logic [3:0] ef [2];
   int         lm [2][4];

   multi_debouncer #(.CHANNELS(4), .TICK_DIV(4), .STABLE_TICKS(STK), .INIT_LEVEL(1'b0)) dut_a (
      .clk(clk), .reset(reset), .in(in_a), .q(q_a), .rise(rise_a), .fall(fall_a));

   multi_debouncer #(.CHANNELS(4), .TICK_DIV(1), .STABLE_TICKS(STK), .INIT_LEVEL(1'b0)) dut_b (
      .clk(clk), .reset(reset), .in(in_b), .q(q_b), .rise(rise_b), .fall(fall_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
      end
   endtask

   function automatic int td_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   // ticks occur at edges e with e % td == td-1; count them in (a, e]
   function automatic int ticks_between(input int a, input int e, input int td);
      return (e + 1) / td - (a + 1) / td;
   endfunction

   // reference model, updated on every edge
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            edge_idx = -1;
            for (int d = 0; d < 2; d++) begin
               mq[d] = 4'b0000;
               er[d] = 4'b0000;
               ef[d] = 4'b0000;
               for (int c = 0; c < 4; c++) lm[d][c] = -1;
            end
         end else begin
            edge_idx++;
            if (edge_idx < HMAX) begin
               in_hist[0][edge_idx] = in_a;
               in_hist[1][edge_idx] = in_b;
            end
            for (int d = 0; d < 2; d++) begin
               er[d] = 4'b0000;
               ef[d] = 4'b0000;
               for (int c = 0; c < 4; c++) begin
                  logic s;
                  s = (edge_idx >= 2 && edge_idx - 2 < HMAX) ? in_hist[d][edge_idx-2][c] : 1'b0;
                  if (s == mq[d][c]) begin
                     lm[d][c] = edge_idx;
                  end else if (ticks_between(lm[d][c], edge_idx, td_of(d)) >= STK) begin
                     mq[d][c] = s;
                     lm[d][c] = edge_idx;
                     if (s) er[d][c] = 1'b1;
                     else   ef[d][c] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // compare on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         check("q_a",    q_a,    mq[0]);
         check("rise_a", rise_a, EDGE_EN ? er[0] : 4'b0000);
         check("fall_a", fall_a, EDGE_EN ? ef[0] : 4'b0000);
         check("q_b",    q_b,    mq[1]);
         check("rise_b", rise_b, EDGE_EN ? er[1] : 4'b0000);
         check("fall_b", fall_b, EDGE_EN ? ef[1] : 4'b0000);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic adv_to(input int target);
      int guard;
      guard = 0;
      while (edge_idx < target && guard < 1000) begin
         step();
         guard++;
      end
      if (edge_idx < target) begin
         n_vec++;
         n_err++;
         $display("FAIL adv_to timeout: actual=%0d required=%0d", edge_idx, target);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // reset state and quiet inputs
      step();
      step();
      check("reset_q_a", q_a, 4'b0000);
      check("reset_rise_a", rise_a, 4'b0000);
      do_reset(1);
      adv_to(99);
      check("idle_q_a", q_a, 4'b0000);
      check("idle_q_b", q_b, 4'b0000);

      // single-cycle tick: step at cycle 10, q and rise at cycle 15
      do_reset(2);
      adv_to(9);
      in_b = 4'b0001;
      adv_to(13);
      check("b_q0_before", q_b, 4'b0000);
      adv_to(14);
      check("b_q0_set", q_b, 4'b0001);
      check("b_rise0_set", rise_b, EDGE_EN ? 4'b0001 : 4'b0000);
      adv_to(15);
      check("b_rise0_drop", rise_b, 4'b0000);
      check("b_q0_hold", q_b, 4'b0001);
      in_b = 4'b0000;

      // all channels together
      in_a = 4'b1111;
      do_reset(2);
      adv_to(10);
      check("a_all_before", q_a, 4'b0000);
      adv_to(11);
      check("a_all_set", q_a, 4'b1111);
      check("a_all_rise", rise_a, EDGE_EN ? 4'b1111 : 4'b0000);
      adv_to(12);
      check("a_all_rise_drop", rise_a, 4'b0000);
      in_a = 4'b0000;
      adv_to(22);
      check("a_all_hold", q_a, 4'b1111);
      adv_to(23);
      check("a_all_clear", q_a, 4'b0000);
      check("a_all_fall", fall_a, EDGE_EN ? 4'b1111 : 4'b0000);
      adv_to(24);
      check("a_all_fall_drop", fall_a, 4'b0000);

      // glitch on channel 1 after two ticks restarts qualification
      do_reset(2);
      adv_to(0);
      in_a = 4'b0010;
      adv_to(8);
      in_a = 4'b0000;
      adv_to(9);
      in_a = 4'b0010;
      adv_to(11);
      check("a_glitch_no_early", q_a, 4'b0000);
      adv_to(22);
      check("a_glitch_before", q_a, 4'b0000);
      adv_to(23);
      check("a_glitch_set", q_a, 4'b0010);
      in_a = 4'b0000;

      // reset while channel 2 is qualifying
      do_reset(2);
      adv_to(0);
      in_a = 4'b0100;
      adv_to(8);
      reset = 1'b1;
      #1;
      check("a_midreset_q", q_a, 4'b0000);
      check("a_midreset_rise", rise_a, 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      adv_to(10);
      check("a_after_reset_before", q_a, 4'b0000);
      adv_to(11);
      check("a_after_reset_set", q_a, 4'b0100);
      adv_to(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1 or more.
REQ-002 Parameter TICK_DIV, default 10000: clk cycles per sample tick, legal range 1 or more; 1 means a tick every cycle.
REQ-003 Parameter STABLE_TICKS, default 8: consecutive mismatching ticks required before q changes, legal range 1 or more.
REQ-004 Parameter INIT_LEVEL, default 0: 1-bit level loaded into q and the synchroniser flops on reset.
REQ-005 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in, input, CHANNELS bits: raw, asynchronous, bouncing inputs.
REQ-008 Port q, output, CHANNELS bits: debounced levels, registered.
REQ-009 Port rise, output, CHANNELS bits: one-cycle pulse when q[i] goes 0->1.
REQ-010 Port fall, output, CHANNELS bits: one-cycle pulse when q[i] goes 1->0.

Function
REQ-011 Each in[i] shall pass through a 2-flop synchroniser; sync[i] is the second flop's output.
REQ-012 A shared prescaler, width $clog2(TICK_DIV) (minimum 1), shall count 0..TICK_DIV-1 and wrap to 0.
REQ-013 The tick signal shall assert in the cycle the prescaler equals TICK_DIV-1, giving one tick per TICK_DIV cycles.
REQ-014 Each channel shall have its own counter cnt[i], width $clog2(STABLE_TICKS+1).
REQ-015 When sync[i]==q[i], cnt[i] shall clear to 0 on that edge, with or without a tick, so any bounce restarts qualification.
REQ-016 When sync[i]!=q[i], tick=1 and cnt[i]<STABLE_TICKS-1, cnt[i] shall increment by 1.
REQ-017 When sync[i]!=q[i], tick=1 and cnt[i]==STABLE_TICKS-1, q[i] shall load sync[i] and cnt[i] shall clear to 0 on the same edge.
REQ-018 cnt[i] shall never exceed STABLE_TICKS-1 and shall never wrap.
REQ-019 Latency from a sustained change at sync[i] to q[i] shall be (STABLE_TICKS-1)*TICK_DIV+1 to STABLE_TICKS*TICK_DIV cycles; add 2 cycles measured from in[i].
REQ-020 With TICK_DIV=1, latency from in[i] to q[i] shall be exactly 2+STABLE_TICKS cycles.
REQ-021 rise[i]/fall[i] shall be registered and high in exactly the cycle q[i] first shows its new value, then low.
REQ-022 rise[i] and fall[i] shall never both be high.
REQ-023 Channels shall be fully independent: simultaneous changes on several channels shall resolve on the same tick.

Reset
REQ-024 While reset is high, q and both synchroniser stages shall be INIT_LEVEL on every channel; prescaler, cnt, rise and fall shall be 0.
REQ-025 A reset asserted mid-qualification shall discard progress immediately, with no edge pulse during or after reset.
REQ-026 After reset deasserts, the first tick shall occur TICK_DIV cycles later.

Configuration
REQ-027 Macro MULTI_DEBOUNCER_EDGE_EN defined: rise and fall shall behave per REQ-021 and REQ-022.
REQ-028 Macro MULTI_DEBOUNCER_EDGE_EN undefined: rise and fall ports shall remain present but tied to 0, with no edge registers synthesised.

Structure
REQ-029 Package debounce_pkg shall hold the parameter defaults and the function computing the counter width (clog2 with a minimum of 1).
REQ-030 Per-channel synchroniser, counter and q/edge logic shall live in sub-module debounce_channel, instantiated CHANNELS times by a generate loop; the prescaler stays in multi_debouncer.

Verification (CHANNELS=4, TICK_DIV=4, STABLE_TICKS=3, INIT_LEVEL=0 unless noted)
REQ-031 Reset, then hold in=4'b0000 for 100 cycles -> q=0, rise=0, fall=0 throughout.
REQ-032 TICK_DIV=1: step in[0] 0->1 at cycle 10 -> q[0]=1 and rise[0]=1 at cycle 15, rise[0]=0 at cycle 16.
REQ-033 Step in[1] 0->1, glitch it to 0 for 1 cycle after 2 ticks, then hold 1 -> q[1] rises only after 3 further full ticks; the glitch causes no pulse.
REQ-034 Step in=4'b1111 simultaneously -> all q bits and rise bits change in the same cycle; the later return to 0 gives fall=4'b1111 for one cycle.
REQ-035 Assert reset for 3 cycles while in[2] is qualifying (cnt=2) -> q[2]=0, no pulse; after release, q[2]=1 needs 3 full ticks.
REQ-036 Build with MULTI_DEBOUNCER_EDGE_EN undefined and repeat REQ-032 -> q behaves identically; rise and fall stay 0.
